// File: rtl/qed_pkg.sv
// Shared constants, FSM state type and ORBIS32 classification/remap helpers
// for the QED replay buffer.
package qed_pkg;

  localparam logic [5:0] OP_LWZ     = 6'h21;
  localparam logic [5:0] OP_SW      = 6'h35;
  localparam logic [5:0] OP_ALU     = 6'h38;
  localparam logic [5:0] OP_ALUI_LO = 6'h27;
  localparam logic [5:0] OP_ALUI_HI = 6'h2C;

  localparam logic [31:0] NOP = 32'h1500_0000;

  typedef enum logic {
    ST_ORIG = 1'b0,
    ST_DUP  = 1'b1
  } state_t;

  // Which register fields of an instruction class get moved to the shadow half.
  typedef struct packed {
    logic rd;
    logic ra;
    logic rb;
  } remap_sel_t;

  function automatic remap_sel_t qed_sel(input logic [5:0] op);
    remap_sel_t sel;
    sel = '0;
    if (op == OP_LWZ) begin
      sel.rd = 1'b1;
      sel.ra = 1'b1;
    end else if (op == OP_SW) begin
      sel.ra = 1'b1;
      sel.rb = 1'b1;
    end else if (op == OP_ALU) begin
      sel.rd = 1'b1;
      sel.ra = 1'b1;
      sel.rb = 1'b1;
    end else if (op >= OP_ALUI_LO && op <= OP_ALUI_HI) begin
      sel.rd = 1'b1;
      sel.ra = 1'b1;
    end
    return sel;
  endfunction

  function automatic logic qed_is_dup(input logic [31:0] instr);
    return qed_sel(instr[31:26]) != '0;
  endfunction

  // Field additions wrap naturally in 5 bits, giving the mod-32 remap.
  function automatic logic [31:0] qed_remap(input logic [31:0] instr, input logic [4:0] offset);
    remap_sel_t  sel;
    logic [31:0] res;
    sel = qed_sel(instr[31:26]);
    res = instr;
    if (sel.rd) res[25:21] = instr[25:21] + offset;
    if (sel.ra) res[20:16] = instr[20:16] + offset;
    if (sel.rb) res[15:11] = instr[15:11] + offset;
    return res;
  endfunction

endpackage

// File: rtl/qed_replay_buffer_if.sv
// Fetch-side and decode-side signal bundle of the QED replay buffer.
interface qed_replay_buffer_if #(
  parameter int unsigned IW    = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ena;
  logic          exec_dup;
  logic          stall_IF;
  logic          ifu_vld;
  logic [IW-1:0] ifu_qed_instruction;
  logic [IW-1:0] qed_ifu_instruction;
  logic          vld_out;
  logic          hold_fetch;
  logic          dup_phase;
  logic [CW-1:0] count;

  modport master (
    output ena, exec_dup, stall_IF, ifu_vld, ifu_qed_instruction,
    input  qed_ifu_instruction, vld_out, hold_fetch, dup_phase, count
  );

  modport slave (
    input  ena, exec_dup, stall_IF, ifu_vld, ifu_qed_instruction,
    output qed_ifu_instruction, vld_out, hold_fetch, dup_phase, count
  );
endinterface

// File: rtl/qed_fifo.sv
// Synchronous FIFO holding original duplicable instructions; flush clears
// pointers and occupancy on the next edge.
module qed_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [IW-1:0]            din,
  output logic [IW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !rst && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + AW'(1);
      cnt    <= cnt + CW'(1);
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/qed_replay_buffer.sv
// QED duplication engine between fetch and decode: passes and buffers original
// instructions, then replays them with shadow-remapped registers while fetch holds.
module qed_replay_buffer
  import qed_pkg::*;
#(
  parameter int unsigned IW         = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned REG_OFFSET = 16
) (
  input  logic                clk,
  input  logic                rst,
  qed_replay_buffer_if.slave  bus
);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam logic [4:0]  OFF = 5'(REG_OFFSET);

  state_t        state;
  state_t        state_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          is_dup;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [IW-1:0] head;

  assign is_dup    = qed_is_dup(bus.ifu_qed_instruction);
  assign bus.count = rst ? '0 : fifo_count;

  qed_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!bus.ena),
    .push  (push),
    .pop   (pop),
    .din   (bus.ifu_qed_instruction),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ORIG;
    else     state <= state_next;
  end

  // Next state, FIFO strobes and the zero-latency output mux.
  always_comb begin
    state_next              = state;
    push                    = 1'b0;
    pop                     = 1'b0;
    count_next              = fifo_count;
    bus.qed_ifu_instruction = bus.ifu_qed_instruction;
    bus.vld_out             = bus.ifu_vld;
    bus.hold_fetch          = 1'b0;
    bus.dup_phase           = 1'b0;

    if (!bus.ena) begin
      state_next = ST_ORIG;
    end else begin
      case (state)
        ST_ORIG: begin
          push       = bus.ifu_vld && is_dup && !full && !bus.stall_IF;
          count_next = fifo_count + CW'(push);
          if (bus.ifu_vld && is_dup && full) bus.vld_out = 1'b0;
          if (!bus.stall_IF && count_next != '0 &&
              (bus.exec_dup || count_next == CW'(DEPTH)))
            state_next = ST_DUP;
        end
        ST_DUP: begin
          bus.qed_ifu_instruction = qed_remap(head, OFF);
          bus.vld_out             = 1'b1;
          bus.hold_fetch          = 1'b1;
          bus.dup_phase           = 1'b1;
          pop                     = !bus.stall_IF && !empty;
          if ((pop && fifo_count == CW'(1)) || empty) state_next = ST_ORIG;
        end
        default: state_next = ST_ORIG;
      endcase
    end

    if (rst) begin
      bus.qed_ifu_instruction = NOP;
      bus.vld_out             = 1'b0;
      bus.hold_fetch          = 1'b0;
      bus.dup_phase           = 1'b0;
    end
  end

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Directed bench for qed_replay_buffer (DEPTH=4, REG_OFFSET=16); every vector
// carries hand-computed outputs for the cycle it is applied in.
module tb_qed_replay_buffer;

  localparam logic [31:0] NOP = 32'h1500_0000;
  // l.add-class r1,r2,r3 with distinct function bits, and their r17,r18,r19 replays
  localparam logic [31:0] A0  = 32'hE022_1800;
  localparam logic [31:0] A1  = 32'hE022_1802;
  localparam logic [31:0] A2  = 32'hE022_1804;
  localparam logic [31:0] R0  = 32'hE232_9800;
  localparam logic [31:0] R1  = 32'hE232_9802;
  localparam logic [31:0] R2  = 32'hE232_9804;
  localparam logic [31:0] L   = 32'h84A6_0000;  // l.lwz r5,0(r6)
  localparam logic [31:0] RL  = 32'h86B6_0000;  // l.lwz r21,0(r22)
  localparam logic [31:0] S   = 32'hD47E_F800;  // l.sw rA=30 rB=31, imm-hi 3
  localparam logic [31:0] RS  = 32'hD46E_7800;  // rA=14 rB=15
  localparam logic [31:0] I   = 32'h9C9F_1234;  // l.addi r4,r31,0x1234
  localparam logic [31:0] RI  = 32'h9E8F_1234;  // l.addi r20,r15,0x1234
  localparam logic [31:0] B   = 32'h1000_0010;  // branch, opcode 0x04
  localparam logic [31:0] X   = 32'hB422_0000;  // opcode 0x2D, just past ALU-imm

  typedef struct packed {
    logic        rst;
    logic        ena;
    logic        exd;
    logic        stall;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] e_ins;
    logic        e_vld;
    logic        e_hold;
    logic        e_dup;
    logic [2:0]  e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  qed_replay_buffer_if #(.IW(32), .DEPTH(4)) bus ();

  qed_replay_buffer #(
    .IW         (32),
    .DEPTH      (4),
    .REG_OFFSET (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic x, input logic s,
                              input logic v, input logic [31:0] i, input logic [31:0] ei,
                              input logic ev, input logic eh, input logic ed,
                              input logic [2:0] ec);
    vec_t t;
    t.rst = r; t.ena = e; t.exd = x; t.stall = s; t.vld = v; t.ins = i;
    t.e_ins = ei; t.e_vld = ev; t.e_hold = eh; t.e_dup = ed; t.e_cnt = ec;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst                     = t.rst;
    bus.ena                 = t.ena;
    bus.exec_dup            = t.exd;
    bus.stall_IF            = t.stall;
    bus.ifu_vld             = t.vld;
    bus.ifu_qed_instruction = t.ins;
  endtask

  task automatic test_reset();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(1,1,0,0,1, A0, NOP,0,0,0,0));
    q.push_back(mk(1,1,1,0,1, A1, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL reset[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,0,0,1, A1,  A1, 1,0,0,1));
    q.push_back(mk(0,1,0,0,1, A2,  A2, 1,0,0,2));
    q.push_back(mk(0,1,1,0,0, NOP, NOP,0,0,0,3));
    q.push_back(mk(0,1,0,0,0, NOP, R0, 1,1,1,3));
    q.push_back(mk(0,1,0,0,1, A0,  R1, 1,1,1,2));
    q.push_back(mk(0,1,0,0,0, NOP, R2, 1,1,1,1));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL basic[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_auto_full();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, L,   L,  1,0,0,0));
    q.push_back(mk(0,1,0,0,1, L,   L,  1,0,0,1));
    q.push_back(mk(0,1,0,0,1, L,   L,  1,0,0,2));
    q.push_back(mk(0,1,0,0,1, L,   L,  1,0,0,3));
    q.push_back(mk(0,1,0,0,1, L,   RL, 1,1,1,4));
    q.push_back(mk(0,1,0,0,1, L,   RL, 1,1,1,3));
    q.push_back(mk(0,1,0,0,1, L,   RL, 1,1,1,2));
    q.push_back(mk(0,1,0,0,1, L,   RL, 1,1,1,1));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL auto_full[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_branch();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, S, S, 1,0,0,0));
    q.push_back(mk(0,1,0,0,1, B, B, 1,0,0,1));
    q.push_back(mk(0,1,0,0,1, I, I, 1,0,0,1));
    q.push_back(mk(0,1,0,0,1, X, X, 1,0,0,2));
    q.push_back(mk(0,1,0,0,0, S, S, 0,0,0,2));
    q.push_back(mk(0,1,1,0,0, B, B, 0,0,0,2));
    q.push_back(mk(0,1,0,0,1, B, RS,1,1,1,2));
    q.push_back(mk(0,1,0,0,1, B, RI,1,1,1,1));
    q.push_back(mk(0,1,0,0,1, B, B, 1,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL sw_branch[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,0,0,1, A1,  A1, 1,0,0,1));
    q.push_back(mk(0,1,1,0,1, A2,  A2, 1,0,0,2));
    q.push_back(mk(0,1,0,0,0, NOP, R0, 1,1,1,3));
    q.push_back(mk(0,1,0,1,0, NOP, R1, 1,1,1,2));
    q.push_back(mk(0,1,0,1,0, NOP, R1, 1,1,1,2));
    q.push_back(mk(0,1,0,0,0, NOP, R1, 1,1,1,2));
    q.push_back(mk(0,1,0,0,0, NOP, R2, 1,1,1,1));
    q.push_back(mk(0,1,0,1,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL stall[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exec_empty();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,1,0,0, B,   B,  0,0,0,0));
    q.push_back(mk(0,1,1,0,1, B,   B,  1,0,0,0));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL exec_empty[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ena_drop();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,0,0,1, A1,  A1, 1,0,0,1));
    q.push_back(mk(0,1,1,0,1, A2,  A2, 1,0,0,2));
    q.push_back(mk(0,1,0,0,0, NOP, R0, 1,1,1,3));
    q.push_back(mk(0,0,0,0,1, B,   B,  1,0,0,2));
    q.push_back(mk(0,1,0,0,1, B,   B,  1,0,0,0));
    q.push_back(mk(0,0,0,0,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL ena_drop[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_dup();
    vec_t q[$];
    logic [37:0] got, want;
    q.push_back(mk(0,1,0,0,1, A0,  A0, 1,0,0,0));
    q.push_back(mk(0,1,1,0,1, A1,  A1, 1,0,0,1));
    q.push_back(mk(0,1,0,0,0, NOP, R0, 1,1,1,2));
    q.push_back(mk(1,1,0,0,1, A0,  NOP,0,0,0,0));
    q.push_back(mk(0,1,0,0,1, B,   B,  1,0,0,0));
    q.push_back(mk(0,1,0,0,0, NOP, NOP,0,0,0,0));
    foreach (q[i]) begin
      drive(q[i]); #1;
      got  = {bus.qed_ifu_instruction, bus.vld_out, bus.hold_fetch, bus.dup_phase, bus.count};
      want = {q[i].e_ins, q[i].e_vld, q[i].e_hold, q[i].e_dup, q[i].e_cnt};
      total++;
      if (got !== want)
        $display("FAIL rst_mid_dup[%0d]: got ins=%h vld=%b hold=%b dup=%b cnt=%0d, want ins=%h vld=%b hold=%b dup=%b cnt=%0d",
                 i, got[37:6], got[5], got[4], got[3], got[2:0], want[37:6], want[5], want[4], want[3], want[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    passed                  = 0;
    total                   = 0;
    rst                     = 1'b1;
    bus.ena                 = 1'b0;
    bus.exec_dup            = 1'b0;
    bus.stall_IF            = 1'b0;
    bus.ifu_vld             = 1'b0;
    bus.ifu_qed_instruction = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_auto_full();
    test_sw_branch();
    test_stall();
    test_exec_empty();
    test_ena_drop();
    test_rst_mid_dup();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
